// File: rtl/ras_circular.sv
// Circular return-address stack with checkpoint/restore for mispredict recovery.
// Ports: clk_i, rst_ni (async low); flush_i, push_i/push_addr_i, pop_i,
//   restore_i/restore_ptr_i/restore_cnt_i in; tos_valid_o, tos_addr_o,
//   ckpt_ptr_o, ckpt_cnt_o out.
module ras_circular #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32,
    parameter int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [VLEN-1:0]  push_addr_i,
    input  logic             pop_i,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_ptr_i,
    input  logic [PTR_W:0]   restore_cnt_i,
    output logic             tos_valid_o,
    output logic [VLEN-1:0]  tos_addr_o,
    output logic [PTR_W-1:0] ckpt_ptr_o,
    output logic [PTR_W:0]   ckpt_cnt_o
);

    localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

    logic [VLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_cnt;

    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic [PTR_W-1:0] w_nxt_ptr;
    logic [PTR_W:0]   w_nxt_cnt;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;

    // DEPTH is a power of two, so PTR_W-bit arithmetic wraps modulo DEPTH.
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr - 1'b1;

    always_comb begin
        w_nxt_ptr = r_ptr;
        w_nxt_cnt = r_cnt;
        w_we      = 1'b0;
        w_waddr   = r_ptr;
        if (flush_i) begin
            w_nxt_ptr = '0;
            w_nxt_cnt = '0;
        end else if (restore_i) begin
            w_nxt_ptr = restore_ptr_i;
            w_nxt_cnt = (restore_cnt_i > L_DEPTH) ? L_DEPTH : restore_cnt_i;
        end else if (push_i && pop_i) begin
            // Return immediately followed by call: replace TOS in place.
            w_we    = 1'b1;
            w_waddr = r_ptr;
        end else if (push_i) begin
            w_we      = 1'b1;
            w_waddr   = w_ptr_inc;
            w_nxt_ptr = w_ptr_inc;
            // When full, the new entry lands on the oldest slot.
            w_nxt_cnt = (r_cnt == L_DEPTH) ? r_cnt : r_cnt + 1'b1;
        end else if (pop_i && (r_cnt != '0)) begin
            w_nxt_ptr = w_ptr_dec;
            w_nxt_cnt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_ptr <= w_nxt_ptr;
            r_cnt <= w_nxt_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[w_waddr] <= push_addr_i;
        end
    end

    assign tos_addr_o  = r_mem[r_ptr];
    assign tos_valid_o = (r_cnt != '0);
    assign ckpt_ptr_o  = r_ptr;
    assign ckpt_cnt_o  = r_cnt;

endmodule

// File: tb/tb_ras_circular.sv
// Self-checking bench for ras_circular: DEPTH=4 vector table plus
// DEPTH=2 and asynchronous-reset hand sequences.
module tb_ras_circular;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        flush, push, pop, restore;
    logic [31:0] addr;
    logic [1:0]  rptr;
    logic [2:0]  rcnt;
    logic        valid;
    logic [31:0] taddr;
    logic [1:0]  cptr;
    logic [2:0]  ccnt;

    ras_circular #(.DEPTH(4), .VLEN(32)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_i(flush), .push_i(push), .push_addr_i(addr),
        .pop_i(pop), .restore_i(restore),
        .restore_ptr_i(rptr), .restore_cnt_i(rcnt),
        .tos_valid_o(valid), .tos_addr_o(taddr),
        .ckpt_ptr_o(cptr), .ckpt_cnt_o(ccnt)
    );

    // DEPTH=2 instance
    logic        d2_push, d2_pop;
    logic [31:0] d2_addr;
    logic        d2_valid;
    logic [31:0] d2_taddr;
    logic [0:0]  d2_cptr;
    logic [1:0]  d2_ccnt;

    ras_circular #(.DEPTH(2), .VLEN(32)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_i(1'b0), .push_i(d2_push), .push_addr_i(d2_addr),
        .pop_i(d2_pop), .restore_i(1'b0),
        .restore_ptr_i(1'b0), .restore_cnt_i(2'b00),
        .tos_valid_o(d2_valid), .tos_addr_o(d2_taddr),
        .ckpt_ptr_o(d2_cptr), .ckpt_cnt_o(d2_ccnt)
    );

    // op bits: [3] flush, [2] push, [1] pop, [0] restore
    localparam logic [3:0] PU = 4'b0100;
    localparam logic [3:0] PO = 4'b0010;
    localparam logic [3:0] PP = 4'b0110;
    localparam logic [3:0] FP = 4'b1100;
    localparam logic [3:0] RP = 4'b0101;
    localparam logic [3:0] RS = 4'b0001;
    localparam logic [3:0] FR = 4'b1011;
    localparam logic [3:0] RO = 4'b0011;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [1:0]  rp;
        logic [2:0]  rc;
        logic        ev;
        logic [31:0] ea;
        logic [1:0]  ep;
        logic [2:0]  ec;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic d2_step(input logic pu, input logic po,
                           input logic [31:0] a);
        @(negedge clk);
        d2_push = pu;
        d2_pop  = po;
        d2_addr = a;
        @(posedge clk);
        #1;
        d2_push = 1'b0;
        d2_pop  = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [1:0] rp, input logic [2:0] rc);
        flush   = op[3];
        push    = op[2];
        pop     = op[1];
        restore = op[0];
        addr    = a;
        rptr    = rp;
        rcnt    = rc;
    endtask

    initial begin
        rst_n   = 1'b0;
        drive(4'b0000, 32'h0, 2'd0, 3'd0);
        d2_push = 1'b0;
        d2_pop  = 1'b0;
        d2_addr = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_addr",  taddr,      32'h0);
        chk("rst_ptr",   32'(cptr),  32'h0);
        chk("rst_cnt",   32'(ccnt),  32'h0);
        chk("rst_d2_valid", 32'(d2_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //          op  addr      rp    rc    ev    ea        ep    ec
        vq.push_back('{PU, 32'h10, 2'd0, 3'd0, 1'b1, 32'h10, 2'd1, 3'd1});
        vq.push_back('{PU, 32'h20, 2'd0, 3'd0, 1'b1, 32'h20, 2'd2, 3'd2});
        vq.push_back('{PU, 32'h30, 2'd0, 3'd0, 1'b1, 32'h30, 2'd3, 3'd3});
        vq.push_back('{PU, 32'h40, 2'd0, 3'd0, 1'b1, 32'h40, 2'd0, 3'd4});
        vq.push_back('{PU, 32'h50, 2'd0, 3'd0, 1'b1, 32'h50, 2'd1, 3'd4});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b1, 32'h40, 2'd0, 3'd3});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b1, 32'h30, 2'd3, 3'd2});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b1, 32'h20, 2'd2, 3'd1});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b0, 32'h50, 2'd1, 3'd0});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b0, 32'h50, 2'd1, 3'd0});
        vq.push_back('{PU, 32'h10, 2'd0, 3'd0, 1'b1, 32'h10, 2'd2, 3'd1});
        vq.push_back('{PP, 32'h99, 2'd0, 3'd0, 1'b1, 32'h99, 2'd2, 3'd1});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b0, 32'h50, 2'd1, 3'd0});
        vq.push_back('{PP, 32'hAA, 2'd0, 3'd0, 1'b0, 32'hAA, 2'd1, 3'd0});
        vq.push_back('{FP, 32'h55, 2'd0, 3'd0, 1'b0, 32'h40, 2'd0, 3'd0});
        vq.push_back('{PU, 32'h10, 2'd0, 3'd0, 1'b1, 32'h10, 2'd1, 3'd1});
        vq.push_back('{PU, 32'h20, 2'd0, 3'd0, 1'b1, 32'h20, 2'd2, 3'd2});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b1, 32'h10, 2'd1, 3'd1});
        vq.push_back('{PU, 32'h77, 2'd0, 3'd0, 1'b1, 32'h77, 2'd2, 3'd2});
        vq.push_back('{PU, 32'h88, 2'd0, 3'd0, 1'b1, 32'h88, 2'd3, 3'd3});
        vq.push_back('{RP, 32'h33, 2'd2, 3'd2, 1'b1, 32'h77, 2'd2, 3'd2});
        vq.push_back('{RS, 32'h0,  2'd1, 3'd7, 1'b1, 32'h10, 2'd1, 3'd4});
        vq.push_back('{FR, 32'h0,  2'd3, 3'd3, 1'b0, 32'h40, 2'd0, 3'd0});
        vq.push_back('{RS, 32'h0,  2'd3, 3'd0, 1'b0, 32'h88, 2'd3, 3'd0});
        vq.push_back('{RO, 32'h0,  2'd0, 3'd4, 1'b1, 32'h40, 2'd0, 3'd4});
        vq.push_back('{PO, 32'h0,  2'd0, 3'd0, 1'b1, 32'h88, 2'd3, 3'd3});

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].op, vq[i].a, vq[i].rp, vq[i].rc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vq[i].ev));
            chk($sformatf("v%0d_addr", i),  taddr,      vq[i].ea);
            chk($sformatf("v%0d_ptr", i),   32'(cptr),  32'(vq[i].ep));
            chk($sformatf("v%0d_cnt", i),   32'(ccnt),  32'(vq[i].ec));
        end
        @(negedge clk);
        drive(4'b0000, 32'h0, 2'd0, 3'd0);

        // DEPTH=2: push A, B then pop three times
        d2_step(1'b1, 1'b0, 32'h100);
        d2_step(1'b1, 1'b0, 32'h200);
        chk("d2_pushB_addr",  d2_taddr,        32'h200);
        chk("d2_pushB_valid", 32'(d2_valid),   32'h1);
        chk("d2_pushB_cnt",   32'(d2_ccnt),    32'h2);
        d2_step(1'b0, 1'b1, 32'h0);
        chk("d2_pop1_addr",   d2_taddr,        32'h100);
        chk("d2_pop1_valid",  32'(d2_valid),   32'h1);
        d2_step(1'b0, 1'b1, 32'h0);
        chk("d2_pop2_valid",  32'(d2_valid),   32'h0);
        chk("d2_pop2_ptr",    32'(d2_cptr),    32'h0);
        d2_step(1'b0, 1'b1, 32'h0);
        chk("d2_pop3_valid",  32'(d2_valid),   32'h0);
        chk("d2_pop3_ptr",    32'(d2_cptr),    32'h0);
        chk("d2_pop3_cnt",    32'(d2_ccnt),    32'h0);
        chk("d2_pop3_addr",   d2_taddr,        32'h200);

        // Three pushes, then reset mid-cycle with push still asserted
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(PU, 32'hA0 + 32'(k), 2'd0, 3'd0);
            @(posedge clk);
        end
        #1;
        chk("pre_rst_cnt",  32'(ccnt), 32'h4);
        chk("pre_rst_addr", taddr,     32'hA2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(valid), 32'h0);
        chk("async_addr",  taddr,      32'h0);
        chk("async_ptr",   32'(cptr),  32'h0);
        chk("async_cnt",   32'(ccnt),  32'h0);
        chk("async_d2_cnt", 32'(d2_ccnt), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_cnt", 32'(ccnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(PU, 32'h5, 2'd0, 3'd0);
        @(posedge clk);
        #1;
        chk("post_rst_addr", taddr,     32'h5);
        chk("post_rst_ptr",  32'(cptr), 32'h1);
        chk("post_rst_cnt",  32'(ccnt), 32'h1);
        @(negedge clk);
        drive(4'b0000, 32'h0, 2'd0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
